// File: rtl/integral_image_builder.sv
// Streaming integral-image generator.
// Turns a raster of gray pixels into ii(x,y) values plus the linear BRAM
// write address y*WIDTH+x. One write is produced per accepted pixel, one
// cycle after the pixel arrives. The address is a running counter, so no
// multiplier is needed.
//
// Pixel interface handshake: the input is valid-only with no backpressure.
// A pixel is transferred in every cycle where pix_valid=1, and pix_sof is
// meaningful only in such a cycle. The block is always ready, so a pixel is
// either accepted or deliberately ignored in the cycle it is presented.
module integral_image_builder #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int PIX_W  = 4,
  parameter int II_W   = 20,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              pix_valid,
  input  logic              pix_sof,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              ii_we,
  output logic [ADDR_W-1:0] ii_addr,
  output logic [II_W-1:0]   ii_data,
  output logic              busy,
  output logic              frame_done,
  output logic              sat,
  output logic [1:0]        state_dbg
);

  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0]   X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]   Y_LAST = YW'(HEIGHT - 1);
  localparam logic [II_W-1:0] II_MAX = {II_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_nxt;

  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [II_W-1:0]   row_q;
  logic [ADDR_W-1:0] addr_q;

  // Previous row's integral values, indexed by column.
  logic [II_W-1:0] linebuf [WIDTH];

  logic              start;
  logic              cont;
  logic              accept;
  logic [XW-1:0]     cur_x;
  logic [YW-1:0]     cur_y;
  logic [ADDR_W-1:0] cur_addr;
  logic [II_W-1:0]   row_base;
  logic [II_W:0]     row_wide;
  logic              row_clamp;
  logic [II_W-1:0]   row_new;
  logic [II_W-1:0]   lb_term;
  logic [II_W:0]     ii_wide;
  logic              ii_clamp;
  logic [II_W-1:0]   ii_new;
  logic              x_last;
  logic              frame_last;

  assign busy      = (state_q == CAPTURE);
  assign state_dbg = state_q;

  // Pixel acceptance, position selection and the two saturating adds.
  always_comb begin
    start      = 1'b0;
    cont       = 1'b0;
    accept     = 1'b0;
    cur_x      = x_q;
    cur_y      = y_q;
    cur_addr   = addr_q;
    row_base   = '0;
    row_wide   = '0;
    row_clamp  = 1'b0;
    row_new    = '0;
    lb_term    = '0;
    ii_wide    = '0;
    ii_clamp   = 1'b0;
    ii_new     = '0;
    x_last     = 1'b0;
    frame_last = 1'b0;

    // An armed SOF restarts the frame at (0,0) from any state.
    start  = pix_valid & pix_sof & enable;
    cont   = pix_valid & ~pix_sof & (state_q == CAPTURE);
    accept = start | cont;

    if (start) begin
      cur_x    = '0;
      cur_y    = '0;
      cur_addr = '0;
    end

    row_base  = (cur_x == '0) ? '0 : row_q;
    row_wide  = {1'b0, row_base} + (II_W + 1)'(pix_data);
    row_clamp = row_wide[II_W];
    row_new   = row_clamp ? II_MAX : row_wide[II_W-1:0];

    // Row 0 has no row above it, so the line buffer is never read there.
    lb_term  = (cur_y == '0) ? '0 : linebuf[cur_x];
    ii_wide  = {1'b0, row_new} + {1'b0, lb_term};
    ii_clamp = ii_wide[II_W];
    ii_new   = ii_clamp ? II_MAX : ii_wide[II_W-1:0];

    x_last     = (cur_x == X_LAST);
    frame_last = accept & x_last & (cur_y == Y_LAST);
  end

  // Next-state logic for the frame FSM.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        if (pix_valid && pix_sof) begin
          // Resync: either restart with this pixel or drop out to IDLE.
          state_nxt = enable ? CAPTURE : IDLE;
        end else if (frame_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = start ? CAPTURE : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  // Position counters, row accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      y_q        <= '0;
      row_q      <= '0;
      addr_q     <= '0;
      ii_we      <= 1'b0;
      ii_addr    <= '0;
      ii_data    <= '0;
      frame_done <= 1'b0;
      sat        <= 1'b0;
    end else begin
      ii_we      <= accept;
      frame_done <= (state_q == DONE);
      if (accept) begin
        ii_addr <= cur_addr;
        ii_data <= ii_new;
        addr_q  <= cur_addr + ADDR_W'(1);
        sat     <= (start ? 1'b0 : sat) | row_clamp | ii_clamp;
        if (x_last) begin
          x_q   <= '0;
          row_q <= '0;
          y_q   <= (cur_y == Y_LAST) ? '0 : cur_y + YW'(1);
        end else begin
          x_q   <= cur_x + XW'(1);
          row_q <= row_new;
          y_q   <= cur_y;
        end
      end
    end
  end

  // Line buffer update; contents need no reset because row 0 never reads it.
  always_ff @(posedge clk) begin
    if (accept && !rst) linebuf[cur_x] <= ii_new;
  end

endmodule

// File: tb/tb_integral_image_builder.sv
// Directed bench for integral_image_builder on a 4x3 frame with 6-bit sums.
module tb_integral_image_builder;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int PIX_W  = 4;
  localparam int II_W   = 6;
  localparam int ADDR_W = 4;
  localparam int NPIX   = WIDTH * HEIGHT;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              pix_valid;
  logic              pix_sof;
  logic [PIX_W-1:0]  pix_data;
  logic              ii_we;
  logic [ADDR_W-1:0] ii_addr;
  logic [II_W-1:0]   ii_data;
  logic              busy;
  logic              frame_done;
  logic              sat;
  logic [1:0]        state_dbg;

  int errors = 0;
  int checks = 0;

  // Stimulus and hand-computed expected integral values.
  logic [PIX_W-1:0] ones_pix [NPIX] = '{default: 4'd1};
  logic [II_W-1:0]  ones_exp [NPIX] = '{6'd1, 6'd2, 6'd3, 6'd4,
                                        6'd2, 6'd4, 6'd6, 6'd8,
                                        6'd3, 6'd6, 6'd9, 6'd12};
  logic [PIX_W-1:0] max_pix  [NPIX] = '{default: 4'd15};
  logic [II_W-1:0]  max_exp  [NPIX] = '{6'd15, 6'd30, 6'd45, 6'd60,
                                        6'd30, 6'd60, 6'd63, 6'd63,
                                        6'd45, 6'd63, 6'd63, 6'd63};
  logic [PIX_W-1:0] rs_pix   [NPIX] = '{4'd5, 4'd1, 4'd1, 4'd1,
                                        4'd1, 4'd1, 4'd1, 4'd1,
                                        4'd1, 4'd1, 4'd1, 4'd1};
  logic [II_W-1:0]  rs_exp   [NPIX] = '{6'd5, 6'd6, 6'd7, 6'd8,
                                        6'd6, 6'd8, 6'd10, 6'd12,
                                        6'd7, 6'd10, 6'd13, 6'd16};

  integral_image_builder #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .PIX_W (PIX_W),
    .II_W  (II_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .pix_valid (pix_valid),
    .pix_sof   (pix_sof),
    .pix_data  (pix_data),
    .ii_we     (ii_we),
    .ii_addr   (ii_addr),
    .ii_data   (ii_data),
    .busy      (busy),
    .frame_done(frame_done),
    .sat       (sat),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of input, then sample #1 after the edge that registers it.
  task automatic send(input logic v, input logic s, input logic [PIX_W-1:0] d);
    pix_valid = v;
    pix_sof   = s;
    pix_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    send(1'b0, 1'b0, '0);
  endtask

  // Plays pixels [first, last) of a frame, checking each write; a complete
  // frame also checks the frame_done pulse and the return to IDLE.
  task automatic play_frame(input string name, input logic [PIX_W-1:0] pix [NPIX],
                            input logic [II_W-1:0] exp [NPIX], input int sat_from,
                            input int gap, input int first, input int last);
    for (int idx = first; idx < last; idx++) begin
      send(1'b1, (idx == 0), pix[idx]);
      checks++;
      if (ii_we !== 1'b1) begin
        errors++;
        $display("FAIL %s we idx=%0d got=%0b exp=1", name, idx, ii_we);
      end
      checks++;
      if (ii_addr !== ADDR_W'(idx)) begin
        errors++;
        $display("FAIL %s addr idx=%0d got=%0d exp=%0d", name, idx, ii_addr, idx);
      end
      checks++;
      if (ii_data !== exp[idx]) begin
        errors++;
        $display("FAIL %s data idx=%0d got=%0d exp=%0d", name, idx, ii_data, exp[idx]);
      end
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL %s early_done idx=%0d got=%0b exp=0", name, idx, frame_done);
      end
      checks++;
      if (busy !== (idx != NPIX - 1)) begin
        errors++;
        $display("FAIL %s busy idx=%0d got=%0b exp=%0b", name, idx, busy, idx != NPIX - 1);
      end
      checks++;
      if (sat !== (idx >= sat_from)) begin
        errors++;
        $display("FAIL %s sat idx=%0d got=%0b exp=%0b", name, idx, sat, idx >= sat_from);
      end
      for (int g = 0; g < gap; g++) begin
        if (idx < NPIX - 1) begin
          idle_cycle();
          checks++;
          if (ii_we !== 1'b0) begin
            errors++;
            $display("FAIL %s gap_we idx=%0d got=%0b exp=0", name, idx, ii_we);
          end
        end
      end
    end
    if (last == NPIX) begin
      idle_cycle();
      checks++;
      if (frame_done !== 1'b1 || ii_we !== 1'b0) begin
        errors++;
        $display("FAIL %s done_pulse got done=%0b we=%0b exp done=1 we=0", name, frame_done, ii_we);
      end
      checks++;
      if (sat !== (sat_from < NPIX)) begin
        errors++;
        $display("FAIL %s sat_hold got=%0b exp=%0b", name, sat, sat_from < NPIX);
      end
      idle_cycle();
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
        errors++;
        $display("FAIL %s after_done got done=%0b busy=%0b st=%0d exp 0/0/0",
                 name, frame_done, busy, state_dbg);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix_data = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ii_we !== 1'b0 || ii_addr !== '0 || ii_data !== '0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || sat !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset outputs got we=%0b addr=%0d data=%0d busy=%0b done=%0b sat=%0b st=%0d exp all 0",
               ii_we, ii_addr, ii_data, busy, frame_done, sat, state_dbg);
    end
    rst = 1'b0;
    idle_cycle();
  endtask

  task automatic test_unit_frame();
    play_frame("unit", ones_pix, ones_exp, 99, 0, 0, NPIX);
  endtask

  task automatic test_gaps();
    play_frame("gaps", ones_pix, ones_exp, 99, 1, 0, NPIX);
  endtask

  task automatic test_arm();
    enable = 1'b0;
    send(1'b1, 1'b1, 4'd1);
    checks++;
    if (ii_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arm_sof got we=%0b busy=%0b exp 0/0", ii_we, busy);
    end
    enable = 1'b1;
    for (int idx = 1; idx < NPIX; idx++) begin
      send(1'b1, 1'b0, 4'd1);
      checks++;
      if (ii_we !== 1'b0 || state_dbg !== 2'd0) begin
        errors++;
        $display("FAIL arm_ignore idx=%0d got we=%0b st=%0d exp 0/0", idx, ii_we, state_dbg);
      end
    end
    idle_cycle();
    play_frame("arm_next", ones_pix, ones_exp, 99, 0, 0, NPIX);
  endtask

  task automatic test_saturation();
    play_frame("sat", max_pix, max_exp, 6, 0, 0, NPIX);
    // A new captured SOF clears the sticky flag.
    play_frame("sat_clear", ones_pix, ones_exp, 99, 0, 0, NPIX);
  endtask

  task automatic test_resync();
    play_frame("rs_pre", ones_pix, ones_exp, 99, 0, 0, 6);
    send(1'b1, 1'b1, 4'd5);
    checks++;
    if (ii_we !== 1'b1 || ii_addr !== '0 || ii_data !== 6'd5 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL resync_first got we=%0b addr=%0d data=%0d done=%0b exp 1/0/5/0",
               ii_we, ii_addr, ii_data, frame_done);
    end
    play_frame("rs_rest", rs_pix, rs_exp, 99, 0, 1, NPIX);
    // Resync with enable low drops the pixel and leaves the frame.
    play_frame("rs_off_pre", ones_pix, ones_exp, 99, 0, 0, 4);
    enable = 1'b0;
    send(1'b1, 1'b1, 4'd9);
    checks++;
    if (ii_we !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL resync_off got we=%0b busy=%0b st=%0d exp 0/0/0", ii_we, busy, state_dbg);
    end
    enable = 1'b1;
    send(1'b1, 1'b0, 4'd1);
    checks++;
    if (ii_we !== 1'b0) begin
      errors++;
      $display("FAIL resync_off_ignore got we=%0b exp=0", ii_we);
    end
  endtask

  task automatic test_mid_reset();
    play_frame("mr_pre", ones_pix, ones_exp, 99, 0, 0, 5);
    rst = 1'b1;
    send(1'b1, 1'b0, 4'd1);
    checks++;
    if (ii_we !== 1'b0 || ii_addr !== '0 || ii_data !== '0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || sat !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset got we=%0b addr=%0d data=%0d busy=%0b done=%0b sat=%0b st=%0d exp all 0",
               ii_we, ii_addr, ii_data, busy, frame_done, sat, state_dbg);
    end
    rst = 1'b0;
    idle_cycle();
    play_frame("mr_after", ones_pix, ones_exp, 99, 0, 0, NPIX);
  endtask

  task automatic test_back_to_back();
    play_frame("b2b_a", ones_pix, ones_exp, 99, 0, 0, NPIX - 1);
    send(1'b1, 1'b0, 4'd1);
    checks++;
    if (ii_we !== 1'b1 || ii_addr !== 4'd11 || ii_data !== 6'd12 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_last got we=%0b addr=%0d data=%0d busy=%0b exp 1/11/12/0",
               ii_we, ii_addr, ii_data, busy);
    end
    // SOF presented while in DONE: new frame starts alongside the done pulse.
    send(1'b1, 1'b1, 4'd1);
    checks++;
    if (ii_we !== 1'b1 || ii_addr !== '0 || ii_data !== 6'd1 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sof got we=%0b addr=%0d data=%0d done=%0b exp 1/0/1/1",
               ii_we, ii_addr, ii_data, frame_done);
    end
    play_frame("b2b_b", ones_pix, ones_exp, 99, 0, 1, NPIX);
  endtask

  initial begin
    test_reset();
    test_unit_frame();
    test_gaps();
    test_arm();
    test_saturation();
    test_resync();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
